// File: rtl/ro_puf_measure_if.sv
`default_nettype none
// ============================================================================
//  Module   : ro_puf_measure_if
//  Purpose  : Bundles the RO bank inputs, challenge/count controls and the
//             count/compare results of the RO-PUF measurement datapath.
//             The master side drives the RO levels, challenge and controls.
//             The slave side is the measurement datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface ro_puf_measure_if #(
  parameter int CNT_W = 16
) ();
  logic [255:0]     ro0;
  logic [255:0]     ro1;
  logic [7:0]       challenge;
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;
  logic             comp_out;
  logic             comp_eq;

  modport master (
    output ro0, ro1, challenge, cnt_en, cnt_clr,
    input  count0, count1, comp_out, comp_eq
  );

  modport slave (
    input  ro0, ro1, challenge, cnt_en, cnt_clr,
    output count0, count1, comp_out, comp_eq
  );
endinterface
`default_nettype wire

// File: rtl/ro_puf_measure.sv
`default_nettype none
// ============================================================================
//  Module   : ro_puf_measure
//  Purpose  : RO-PUF measurement datapath. Two 256:1 challenge muxes select
//             one RO per bank; each selected RO is synchronised, rising-edge
//             detected and counted. A magnitude comparator yields the
//             response bit (count0 > count1) and a tie flag.
//  Config   : RO_PUF_CNT_SAT_EN - when defined, counters saturate at all-ones
//             instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module ro_puf_measure #(
  parameter int CNT_W  = 16,
  parameter int SYNC_N = 2
) (
  input  logic              clk,
  input  logic              rst,   // synchronous, active-low
  ro_puf_measure_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Selected RO per bank; same index drives both muxes.
  logic [1:0]       w_mux;
  logic [CNT_W-1:0] w_count0;
  logic [CNT_W-1:0] w_count1;

  assign w_mux[0] = bus.ro0[bus.challenge];
  assign w_mux[1] = bus.ro1[bus.challenge];

  for (genvar b = 0; b < 2; b++) begin : g_path
    logic [SYNC_N-1:0] r_sync;
    logic              r_hist;
    logic [CNT_W-1:0]  r_count;
    logic              w_rise;

    // Rising edge of the synchronised RO, one cycle wide.
    assign w_rise = r_sync[SYNC_N-1] & ~r_hist;

    // Synchroniser and edge history; a clear flushes them so an edge that
    // straddles the clear is dropped rather than counted afterwards.
    always_ff @(posedge clk) begin
      if (!rst || bus.cnt_clr) begin
        r_sync <= '0;
        r_hist <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_N-2:0], w_mux[b]};
        r_hist <= r_sync[SYNC_N-1];
      end
    end

    // Edge counter: reset, then clear, then enabled increment, else hold.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_count <= '0;
      end else if (bus.cnt_clr) begin
        r_count <= '0;
      end else if (bus.cnt_en && w_rise) begin
`ifdef RO_PUF_CNT_SAT_EN
        if (r_count != {CNT_W{1'b1}}) begin
          r_count <= r_count + c_one;
        end
`else
        r_count <= r_count + c_one;
`endif
      end
    end
  end

  assign w_count0 = g_path[0].r_count;
  assign w_count1 = g_path[1].r_count;

  assign bus.count0   = w_count0;
  assign bus.count1   = w_count1;
  // Unsigned compare; a tie gives a 0 response and raises the tie flag.
  assign bus.comp_out = (w_count0 > w_count1);
  assign bus.comp_eq  = (w_count0 == w_count1);

endmodule
`default_nettype wire

// File: tb/tb_ro_puf_measure.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ro_puf_measure
//  Purpose  : Self-checking bench for ro_puf_measure. A 16-bit instance runs
//             the table of challenge/RO-pattern vectors plus reset, isolation,
//             enable/clear and latency sequences; a 4-bit instance exercises
//             counter wrap (or saturation with RO_PUF_CNT_SAT_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ro_puf_measure;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ro_puf_measure_if #(.CNT_W(16)) bus  ();
  ro_puf_measure_if #(.CNT_W(4))  bus4 ();

  ro_puf_measure #(.CNT_W(16), .SYNC_N(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  ro_puf_measure #(.CNT_W(4),  .SYNC_N(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [7:0]  ch;
    int          half0;   // RO half-period in clk cycles, 0 = held low
    int          half1;
    int          ncyc;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        eo;
    logic        eq;
  } vec_t;

  typedef struct {
    logic [15:0] c0;
    logic [15:0] c1;
    logic        o;
    logic        q;
  } exp_t;

  vec_t vecs [5];
  exp_t sb_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic lvl(input int i, input int half);
    return (half != 0) && (((i / half) % 2) == 1);
  endfunction

  // Drive the selected RO bits; all other RO bits get random noise.
  task automatic set_ro(input logic [7:0] ch, input logic l0, input logic l1);
    logic [255:0] a;
    logic [255:0] b;
    a = rnd256();
    b = rnd256();
    a[ch] = l0;
    b[ch] = l1;
    bus.ro0 = a;
    bus.ro1 = b;
  endtask

  task automatic clear_main(input logic [7:0] ch);
    bus.challenge = ch;
    bus.cnt_en    = 1'b0;
    bus.cnt_clr   = 1'b1;
    set_ro(ch, 1'b0, 1'b0);
    tick();
    bus.cnt_clr   = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;

    //            ch     h0 h1 ncyc  e0     e1     out   eq
    vecs[0] = '{8'd5,   4, 8, 64, 16'd8,  16'd4,  1'b1, 1'b0};
    vecs[1] = '{8'd0,   2, 2, 40, 16'd10, 16'd10, 1'b0, 1'b1};
    vecs[2] = '{8'd255, 3, 2, 36, 16'd6,  16'd9,  1'b0, 1'b0};
    vecs[3] = '{8'd128, 5, 0, 50, 16'd5,  16'd0,  1'b1, 1'b0};
    vecs[4] = '{8'd77,  8, 2, 32, 16'd2,  16'd8,  1'b0, 1'b0};

    // ---------------- reset with RO activity ----------------
    rst            = 1'b0;
    bus.challenge  = 8'd0;
    bus.cnt_en     = 1'b1;
    bus.cnt_clr    = 1'b0;
    bus4.challenge = 8'd3;
    bus4.cnt_en    = 1'b0;
    bus4.cnt_clr   = 1'b0;
    bus4.ro0       = '0;
    bus4.ro1       = '0;
    set_ro(8'd0, 1'b1, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      set_ro(8'd0, lvl(i, 1), ~lvl(i, 1));
      tick();
    end
    check("reset_count0", 32'(bus.count0), 32'd0);
    check("reset_count1", 32'(bus.count1), 32'd0);
    check("reset_comp_out", 32'(bus.comp_out), 32'd0);
    check("reset_comp_eq", 32'(bus.comp_eq), 32'd1);
    check("reset_count0_w4", 32'(bus4.count0), 32'd0);
    rst = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < 5; v++) begin
      clear_main(vecs[v].ch);
      bus.cnt_en = 1'b1;
      e.c0 = vecs[v].e0;
      e.c1 = vecs[v].e1;
      e.o  = vecs[v].eo;
      e.q  = vecs[v].eq;
      sb_q.push_back(e);
      for (int i = 0; i < vecs[v].ncyc; i++) begin
        set_ro(vecs[v].ch, lvl(i, vecs[v].half0), lvl(i, vecs[v].half1));
        tick();
      end
      for (int j = 0; j < 4; j++) begin
        set_ro(vecs[v].ch, lvl(vecs[v].ncyc - 1, vecs[v].half0),
               lvl(vecs[v].ncyc - 1, vecs[v].half1));
        tick();
      end
      bus.cnt_en = 1'b0;
      if (sb_q.size() == 0) begin
        check("vec_scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("vec%0d_count0", v), 32'(bus.count0), 32'(e.c0));
        check($sformatf("vec%0d_count1", v), 32'(bus.count1), 32'(e.c1));
        check($sformatf("vec%0d_comp_out", v), 32'(bus.comp_out), 32'(e.o));
        check($sformatf("vec%0d_comp_eq", v), 32'(bus.comp_eq), 32'(e.q));
      end
    end

    // ---------------- index isolation ----------------
    clear_main(8'd255);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 44; i++) begin
      logic [255:0] a;
      logic [255:0] b;
      a = '0;
      b = '0;
      a[254] = lvl(i, 2);
      b[0]   = lvl(i, 2);
      bus.ro0 = a;
      bus.ro1 = b;
      tick();
    end
    check("iso_count0", 32'(bus.count0), 32'd0);
    check("iso_count1", 32'(bus.count1), 32'd0);
    check("iso_comp_eq", 32'(bus.comp_eq), 32'd1);

    // ---------------- enable hold and clear-beats-rise ----------------
    clear_main(8'd10);
    bus.cnt_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_ro(8'd10, lvl(i, 2), 1'b0);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      set_ro(8'd10, lvl(39, 2), 1'b0);
      tick();
    end
    check("en_count0_10", 32'(bus.count0), 32'd10);
    bus.cnt_en = 1'b0;
    for (int i = 40; i < 60; i++) begin
      set_ro(8'd10, lvl(i, 2), 1'b0);
      tick();
    end
    check("en_hold_count0", 32'(bus.count0), 32'd10);
    check("en_hold_comp_out", 32'(bus.comp_out), 32'd1);
    for (int j = 0; j < 3; j++) begin
      set_ro(8'd10, 1'b0, 1'b0);
      tick();
    end
    bus.cnt_en = 1'b1;
    set_ro(8'd10, 1'b1, 1'b0);
    tick();                       // edge k: first sample of the high level
    set_ro(8'd10, 1'b1, 1'b0);
    tick();                       // edge k+1: rise now pending
    bus.cnt_clr = 1'b1;
    set_ro(8'd10, 1'b1, 1'b0);
    tick();                       // edge k+2: clear coincides with rise
    check("clr_vs_rise_count0", 32'(bus.count0), 32'd0);
    bus.cnt_clr = 1'b0;
    for (int j = 0; j < 4; j++) begin
      set_ro(8'd10, 1'b0, 1'b0);
      tick();
    end
    check("clr_after_count0", 32'(bus.count0), 32'd0);
    check("clr_after_comp_eq", 32'(bus.comp_eq), 32'd1);

    // ---------------- latency: rise sampled at k counts at k+2 ----------------
    clear_main(8'd200);
    bus.cnt_en = 1'b1;
    for (int j = 0; j < 2; j++) begin
      set_ro(8'd200, 1'b0, 1'b0);
      tick();
    end
    set_ro(8'd200, 1'b1, 1'b0);
    tick();
    check("lat_edge_k", 32'(bus.count0), 32'd0);
    set_ro(8'd200, 1'b1, 1'b0);
    tick();
    check("lat_edge_k1", 32'(bus.count0), 32'd0);
    set_ro(8'd200, 1'b1, 1'b0);
    tick();
    check("lat_edge_k2", 32'(bus.count0), 32'd1);
    bus.cnt_en = 1'b0;

    // ---------------- wrap / saturation on the 4-bit instance ----------------
    bus4.cnt_clr = 1'b1;
    tick();
    bus4.cnt_clr = 1'b0;
    bus4.cnt_en  = 1'b1;
    for (int i = 0; i < 72; i++) begin
      logic [255:0] a;
      a = '0;
      a[3] = lvl((i < 68) ? i : 67, 2);   // 17 rising edges
      bus4.ro0 = a;
      tick();
    end
`ifdef RO_PUF_CNT_SAT_EN
    check("sat_count0", 32'(bus4.count0), 32'd15);
`else
    check("wrap_count0", 32'(bus4.count0), 32'd1);
`endif
    check("w4_comp_out", 32'(bus4.comp_out), 32'd1);
    check("w4_comp_eq", 32'(bus4.comp_eq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
